instruction_encoder: RTL

Packs a signed immediate back into the scattered instruction-bit positions of a 32-bit RV32 instruction word, producing a complete instruction from a template. It performs the inverse of the immediate-decode step. It also expands a 32-bit load-immediate into a LUI/ADDI sequence. It sits between the debug/boot loader's command path and instruction memory, so the loader can synthesize trampolines and constant loads in hardware. Input and output are both valid/ready streams, and the output is registered.

---
 rtl/instruction_encoder_pkg.sv | 38 +++
 rtl/instruction_encoder_immediate_packer.sv | 60 ++++++
 rtl/instruction_encoder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg
//   Shared constants for the RV32 instruction encoder: data width, immediate
//   format select codes, the opcodes used by load-immediate expansion and the
//   encoder FSM state encoding.
//   Also provides fits_signed(), which tells whether a value survives
//   sign-extension from a given bit position.
//   Optional feature macro used by the encoder: LI_EXPANSION_EN.
package instruction_encoder_pkg;

  localparam int XLEN          = 32;
  localparam int IMM_SEL_WIDTH = 2;

  localparam logic [IMM_SEL_WIDTH:0] IMM_I_TYPE = 3'd0;
  localparam logic [IMM_SEL_WIDTH:0] IMM_S_TYPE = 3'd1;
  localparam logic [IMM_SEL_WIDTH:0] IMM_B_TYPE = 3'd2;
  localparam logic [IMM_SEL_WIDTH:0] IMM_U_TYPE = 3'd3;
  localparam logic [IMM_SEL_WIDTH:0] IMM_J_TYPE = 3'd4;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    EMIT_SINGLE = 2'd1,
    EMIT_LUI    = 2'd2,
    EMIT_ADDI   = 2'd3
  } enc_state_e;

  // True when every bit from msb upward equals the sign bit, i.e. the value
  // is representable as a signed field whose top bit is msb.
  function automatic logic fits_signed(input logic [XLEN-1:0] value,
                                       input int unsigned msb);
    logic [XLEN-1:0] upper;
    upper = XLEN'($signed(value) >>> msb);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instruction_encoder_immediate_packer.sv
// immediate_packer
//   Purely combinational. Scatters a two's-complement immediate into the
//   instruction-bit positions of the selected RV32 format; every other bit
//   comes from the template. Flags immediates the format cannot represent
//   (the field is still filled with the truncated value).
// Ports
//   i_select        immediate format code (IMM_*_TYPE)
//   i_immediate     immediate value
//   i_template      instruction template
//   o_instruction   template with the immediate field overwritten
//   o_range_error   immediate out of range, misaligned, or unknown select
module immediate_packer
  import instruction_encoder_pkg::*;
(
  input  logic [IMM_SEL_WIDTH:0] i_select,
  input  logic [XLEN-1:0]        i_immediate,
  input  logic [XLEN-1:0]        i_template,
  output logic [XLEN-1:0]        o_instruction,
  output logic                   o_range_error
);

  always_comb begin
    o_instruction = i_template;
    o_range_error = 1'b0;
    case (i_select)
      IMM_I_TYPE: begin
        o_instruction[31:20] = i_immediate[11:0];
        o_range_error        = !fits_signed(i_immediate, 11);
      end
      IMM_S_TYPE: begin
        o_instruction[31:25] = i_immediate[11:5];
        o_instruction[11:7]  = i_immediate[4:0];
        o_range_error        = !fits_signed(i_immediate, 11);
      end
      IMM_B_TYPE: begin
        // imm[0] has no slot; an odd offset is flagged and its LSB dropped.
        o_instruction[31]    = i_immediate[12];
        o_instruction[30:25] = i_immediate[10:5];
        o_instruction[11:8]  = i_immediate[4:1];
        o_instruction[7]     = i_immediate[11];
        o_range_error        = !fits_signed(i_immediate, 12) || i_immediate[0];
      end
      IMM_U_TYPE: begin
        o_instruction[31:12] = i_immediate[31:12];
        o_range_error        = |i_immediate[11:0];
      end
      IMM_J_TYPE: begin
        o_instruction[31]    = i_immediate[20];
        o_instruction[30:21] = i_immediate[10:1];
        o_instruction[20]    = i_immediate[11];
        o_instruction[19:12] = i_immediate[19:12];
        o_range_error        = !fits_signed(i_immediate, 20) || i_immediate[0];
      end
      default: begin
        o_range_error = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder
//   Builds complete RV32 instruction words for the loader: packs an immediate
//   into a template (single encode) or, with LI_EXPANSION_EN defined, expands
//   a 32-bit load-immediate into LUI and/or ADDI. Valid/ready on both sides,
//   registered output, one instruction per cycle when not back-pressured.
//   Without LI_EXPANSION_EN, i_Mode/i_Rd are ignored and o_Last is always 1.
// Ports
//   i_Clock, i_Reset       clock, synchronous active-low reset
//   i_Valid / o_Ready      request handshake
//   i_Mode                 0 = single encode, 1 = load-immediate expansion
//   i_Imm_Select           immediate format for single encode
//   i_Template             template bits kept outside the immediate field
//   i_Immediate            immediate value (two's complement)
//   i_Rd                   destination register for expansion
//   o_Valid / i_Ready      output handshake
//   o_Instruction          encoded instruction
//   o_Range_Error          immediate not representable (with o_Valid)
//   o_Last                 final instruction of the current request
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Valid,
  output logic                   o_Ready,
  input  logic                   i_Mode,
  input  logic [IMM_SEL_WIDTH:0] i_Imm_Select,
  input  logic [XLEN-1:0]        i_Template,
  input  logic [XLEN-1:0]        i_Immediate,
  input  logic [4:0]             i_Rd,
  output logic                   o_Valid,
  input  logic                   i_Ready,
  output logic [XLEN-1:0]        o_Instruction,
  output logic                   o_Range_Error,
  output logic                   o_Last
);

  enc_state_e             state_q, state_d;
  logic [XLEN-1:0]        instr_q, instr_d;
  logic                   range_err_q, range_err_d;

  logic [IMM_SEL_WIDTH:0] pk_select;
  logic [XLEN-1:0]        pk_immediate;
  logic [XLEN-1:0]        pk_template;
  logic [XLEN-1:0]        pk_instruction;
  logic                   pk_range_error;

  logic                   consume;
  logic                   accept;

  assign o_Valid       = (state_q != IDLE);
  assign o_Instruction = instr_q;
  assign o_Range_Error = range_err_q;
  assign consume       = o_Valid && i_Ready;
  assign accept        = i_Valid && o_Ready;

  immediate_packer u_packer (
    .i_select      (pk_select),
    .i_immediate   (pk_immediate),
    .i_template    (pk_template),
    .o_instruction (pk_instruction),
    .o_range_error (pk_range_error)
  );

`ifdef LI_EXPANSION_EN
  logic        last_q, last_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic [11:0] li_lo;
  logic [19:0] li_hi;

  // Adding 0x800 before taking the upper bits only carries in from bit 11,
  // which compensates for ADDI sign-extending its 12-bit operand.
  assign li_lo   = i_Immediate[11:0];
  assign li_hi   = i_Immediate[31:12] + {19'd0, i_Immediate[11]};
  assign o_Ready = i_Reset && ((state_q == IDLE) || (consume && last_q));
  assign o_Last  = last_q;

  // The single packer serves three sources: the pending ADDI of a two-beat
  // expansion (no request can be accepted then), the first beat of a new
  // expansion, or a plain single encode.
  always_comb begin
    pk_select    = i_Imm_Select;
    pk_immediate = i_Immediate;
    pk_template  = i_Template;
    if ((state_q == EMIT_LUI) && !last_q) begin
      pk_select    = IMM_I_TYPE;
      pk_immediate = {{20{lo_q[11]}}, lo_q};
      pk_template  = {12'd0, rd_q, 3'b000, rd_q, OP_OP_IMM};
    end else if (i_Mode) begin
      if (li_hi == '0) begin
        pk_select    = IMM_I_TYPE;
        pk_immediate = {{20{li_lo[11]}}, li_lo};
        pk_template  = {12'd0, 5'd0, 3'b000, i_Rd, OP_OP_IMM};
      end else begin
        pk_select    = IMM_U_TYPE;
        pk_immediate = {li_hi, 12'd0};
        pk_template  = {20'd0, i_Rd, OP_LUI};
      end
    end
  end

  // A new accept always wins over advancing the current request; it can only
  // coincide with consuming a final beat, so nothing is lost.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    range_err_d = range_err_q;
    last_d      = last_q;
    rd_d        = rd_q;
    lo_d        = lo_q;
    if (accept) begin
      instr_d = pk_instruction;
      if (i_Mode) begin
        range_err_d = 1'b0;
        rd_d        = i_Rd;
        lo_d        = li_lo;
        if (li_hi == '0) begin
          state_d = EMIT_ADDI;
          last_d  = 1'b1;
        end else begin
          state_d = EMIT_LUI;
          last_d  = (li_lo == '0);
        end
      end else begin
        state_d     = EMIT_SINGLE;
        range_err_d = pk_range_error;
        last_d      = 1'b1;
      end
    end else if (consume) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        state_d     = EMIT_ADDI;
        instr_d     = pk_instruction;
        range_err_d = 1'b0;
        last_d      = 1'b1;
      end
    end
  end
`else
  logic unused_li_inputs;

  assign unused_li_inputs = ^{i_Mode, i_Rd};
  assign o_Ready          = i_Reset && ((state_q == IDLE) || consume);
  assign o_Last           = 1'b1;
  assign pk_select        = i_Imm_Select;
  assign pk_immediate     = i_Immediate;
  assign pk_template      = i_Template;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    range_err_d = range_err_q;
    if (accept) begin
      state_d     = EMIT_SINGLE;
      instr_d     = pk_instruction;
      range_err_d = pk_range_error;
    end else if (consume) begin
      state_d = IDLE;
    end
  end
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Reset) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      range_err_q <= 1'b0;
`ifdef LI_EXPANSION_EN
      last_q      <= 1'b0;
      rd_q        <= '0;
      lo_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      range_err_q <= range_err_d;
`ifdef LI_EXPANSION_EN
      last_q      <= last_d;
      rd_q        <= rd_d;
      lo_q        <= lo_d;
`endif
    end
  end

endmodule
